// File: rtl/conv_compute_scheduler_pkg.sv
// Shared definitions for the convolution compute scheduler: default
// parameter values, FSM state encodings and the channel-group helper.
package conv_compute_scheduler_pkg;

  localparam int FEAT_W_DEF     = 11;
  localparam int ADDR_W_DEF     = 7;
  localparam int LANES_DEF      = 8;
  localparam int MAX_GROUPS_DEF = 8;
  localparam int PIPE_LAT_DEF   = 14;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_FIFO  = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_COMPUTE    = 3'd4,
    ST_ROW_END    = 3'd5
  } state_t;

  // Number of channel groups for a job: ceil(channels/lanes), at least one
  // group so a zero channel count still runs, and never more than the
  // datapath can select.
  function automatic int calcGroups(input logic [7:0] chOut,
                                    input int lanes,
                                    input int maxGroups);
    int g;
    g = (int'(chOut) + lanes - 1) / lanes;
    if (g < 1) g = 1;
    if (g > maxGroups) g = maxGroups;
    return g;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth single-bit shift register that models the datapath latency
// for strobes; a reset flushes every stage so nothing in flight escapes.
module valid_delay_line
  import conv_compute_scheduler_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_dout
);

  logic [DEPTH-1:0] r_stages;

  // Shift the strobe one stage per cycle; stage DEPTH-1 is the output.
  always_ff @(posedge clk) begin
    if (rst) r_stages <= '0;
    else     r_stages <= (r_stages << 1) | DEPTH'(i_din);
  end

  assign o_dout = r_stages[DEPTH-1];

endmodule

// File: rtl/conv_compute_scheduler.sv
// Convolution compute scheduler: loads weights, then walks rows, columns
// and channel groups, issuing one group per cycle while downstream is ready.
module conv_compute_scheduler
  import conv_compute_scheduler_pkg::*;
#(
  parameter int FEAT_W     = FEAT_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int MAX_GROUPS = MAX_GROUPS_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FEAT_W-1:0]     col_num,
  input  logic [FEAT_W-1:0]     row_num,
  input  logic [7:0]            channel_out_num,
  input  logic [ADDR_W-1:0]     load_len,
  input  logic                  fifo_ready,
  input  logic                  m_ready,
  output logic                  rd_en_fifo,
  output logic [ADDR_W-1:0]     weight_addrb,
  output logic [MAX_GROUPS-1:0] weight_select,
  output logic                  m_valid,
  output logic                  compute_complete,
  output logic                  conv_complete,
  output logic                  busy
);

  // Group counter must hold values up to MAX_GROUPS (the latched count).
  localparam int GRP_W = $clog2(MAX_GROUPS) + 1;

  state_t                r_state;
  state_t                w_nextState;
  logic [FEAT_W-1:0]     r_colNum;
  logic [FEAT_W-1:0]     r_rowNum;
  logic [FEAT_W-1:0]     r_colCnt;
  logic [FEAT_W-1:0]     r_rowCnt;
  logic [ADDR_W-1:0]     r_loadLen;
  logic [ADDR_W-1:0]     r_weightAddr;
  logic [GRP_W-1:0]      r_groups;
  logic [GRP_W-1:0]      r_groupCnt;
  logic                  r_rdEn;
  logic [MAX_GROUPS-1:0] r_weightSel;

  logic w_issue;
  logic w_busy;
  logic w_computeComplete;
  logic w_lastGroup;
  logic w_lastCol;
  logic w_lastRow;
  logic w_loadDone;

  assign w_lastGroup = (r_groupCnt == r_groups - GRP_W'(1));
  assign w_lastCol   = (r_colCnt == r_colNum - FEAT_W'(1));
  assign w_lastRow   = (r_rowCnt + FEAT_W'(1) == r_rowNum);
  assign w_loadDone  = (r_weightAddr == r_loadLen);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic; start is only looked at in IDLE so it is ignored while busy.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:       if (start)      w_nextState = ST_LOAD;
      ST_LOAD:       if (w_loadDone) w_nextState = ST_WAIT_FIFO;
      ST_WAIT_FIFO:  if (fifo_ready) w_nextState = ST_WAIT_READY;
      ST_WAIT_READY: if (m_ready)    w_nextState = ST_COMPUTE;
      ST_COMPUTE:    if (m_ready && w_lastGroup && w_lastCol) w_nextState = ST_ROW_END;
      ST_ROW_END:    w_nextState = w_lastRow ? ST_IDLE : ST_WAIT_FIFO;
      default:       w_nextState = ST_IDLE;
    endcase
  end

  // State-decoded outputs: issue strobe, busy and the final-row completion pulse.
  always_comb begin
    w_busy            = (r_state != ST_IDLE);
    w_issue           = (r_state == ST_COMPUTE) && m_ready;
    w_computeComplete = (r_state == ST_ROW_END) && w_lastRow;
  end

  // Capture job geometry at start, forcing zero sizes up to one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_colNum  <= '0;
      r_rowNum  <= '0;
      r_loadLen <= '0;
      r_groups  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_colNum  <= (col_num == '0) ? FEAT_W'(1) : col_num;
      r_rowNum  <= (row_num == '0) ? FEAT_W'(1) : row_num;
      r_loadLen <= load_len;
      r_groups  <= GRP_W'(calcGroups(channel_out_num, LANES, MAX_GROUPS));
    end
  end

  // Weight load address: counts up in LOAD, stops at load_len, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst)                                   r_weightAddr <= '0;
    else if (r_state == ST_LOAD && !w_loadDone) r_weightAddr <= r_weightAddr + ADDR_W'(1);
    else                                       r_weightAddr <= '0;
  end

  // Group/column walk; a stall leaves both counters untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_groupCnt <= '0;
      r_colCnt   <= '0;
    end else if (w_issue) begin
      if (w_lastGroup) begin
        r_groupCnt <= '0;
        r_colCnt   <= w_lastCol ? '0 : r_colCnt + FEAT_W'(1);
      end else begin
        r_groupCnt <= r_groupCnt + GRP_W'(1);
      end
    end
  end

  // Row counter advances at each row end and clears when the job finishes.
  always_ff @(posedge clk) begin
    if (rst)                      r_rowCnt <= '0;
    else if (r_state == ST_ROW_END) r_rowCnt <= w_lastRow ? '0 : r_rowCnt + FEAT_W'(1);
  end

  // Registered FIFO pop after each column's last group, and the group select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdEn      <= 1'b0;
      r_weightSel <= MAX_GROUPS'(1);
    end else begin
      r_rdEn      <= w_issue && w_lastGroup;
      r_weightSel <= (r_state == ST_COMPUTE) ? (MAX_GROUPS'(1) << r_groupCnt)
                                             : MAX_GROUPS'(1);
    end
  end

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_validDelay (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_issue),
    .o_dout (m_valid)
  );

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_completeDelay (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_computeComplete),
    .o_dout (conv_complete)
  );

  assign rd_en_fifo       = r_rdEn;
  assign weight_addrb     = r_weightAddr;
  assign weight_select    = r_weightSel;
  assign compute_complete = w_computeComplete;
  assign busy             = w_busy;

endmodule

// File: tb/tb_conv_compute_scheduler.sv
// Scoreboard bench for conv_compute_scheduler: each started job pushes its
// expected totals, which are compared when the job's conv_complete appears.
module tb_conv_compute_scheduler;

  localparam int FEAT_W     = 11;
  localparam int ADDR_W     = 7;
  localparam int LANES      = 8;
  localparam int MAX_GROUPS = 8;
  localparam int PIPE_LAT   = 14;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [FEAT_W-1:0]     colNum;
  logic [FEAT_W-1:0]     rowNum;
  logic [7:0]            chOut;
  logic [ADDR_W-1:0]     loadLen;
  logic                  fifoReady;
  logic                  mReady;
  logic                  rdEn;
  logic [ADDR_W-1:0]     weightAddrb;
  logic [MAX_GROUPS-1:0] weightSelect;
  logic                  mValid;
  logic                  computeComplete;
  logic                  convComplete;
  logic                  busy;

  conv_compute_scheduler #(
    .FEAT_W(FEAT_W), .ADDR_W(ADDR_W), .LANES(LANES),
    .MAX_GROUPS(MAX_GROUPS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .col_num          (colNum),
    .row_num          (rowNum),
    .channel_out_num  (chOut),
    .load_len         (loadLen),
    .fifo_ready       (fifoReady),
    .m_ready          (mReady),
    .rd_en_fifo       (rdEn),
    .weight_addrb     (weightAddrb),
    .weight_select    (weightSelect),
    .m_valid          (mValid),
    .compute_complete (computeComplete),
    .conv_complete    (convComplete),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // gapMode: 0 = gap not checked, 1 = largest m_valid gap must equal gapVal,
  // 2 = largest gap must be at least gapVal.
  typedef struct {
    int groups;
    int loadNz;
    int issues;
    int rdEn;
    int gapMode;
    int gapVal;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;

  int   obsLoadNz, obsMaxAddr, obsValid, obsRdEn, obsCc, ccCycle, lastValidCycle, maxGap;
  logic [MAX_GROUPS-1:0] prevWsel = 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic void resetMonitor();
    obsLoadNz      = 0;
    obsMaxAddr     = 0;
    obsValid       = 0;
    obsRdEn        = 0;
    obsCc          = 0;
    ccCycle        = 0;
    lastValidCycle = -1;
    maxGap         = 0;
  endfunction

  // Drive one job and push what it must produce.
  task automatic applyStimulus(input int col, input int row, input int ch,
                               input int ld, input int gapMode, input int gapVal);
    exp_t e;
    int   g, c1, r1;
    g  = (ch + LANES - 1) / LANES;
    if (g < 1) g = 1;
    if (g > MAX_GROUPS) g = MAX_GROUPS;
    c1 = (col == 0) ? 1 : col;
    r1 = (row == 0) ? 1 : row;
    e.groups  = g;
    e.loadNz  = ld;
    e.issues  = g * c1 * r1;
    e.rdEn    = c1 * r1;
    e.gapMode = gapMode;
    e.gapVal  = gapVal;
    sbQ.push_back(e);
    colNum  = FEAT_W'(col);
    rowNum  = FEAT_W'(row);
    chOut   = 8'(ch);
    loadLen = ADDR_W'(ld);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic waitJobDone(input int budget);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("jobTimeout", 0, 1);
      sbQ.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic waitRdEn(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdEn && n < budget);
    if (!rdEn) checkOutput("rdEnTimeout", 0, 1);
  endtask

  // Monitor: accumulate per-job observations and settle them against the
  // scoreboard when conv_complete marks the job's end.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (rst) begin
      resetMonitor();
      prevWsel = weightSelect;
    end else begin
      if (weightAddrb != '0) obsLoadNz++;
      if (int'(weightAddrb) > obsMaxAddr) obsMaxAddr = int'(weightAddrb);
      if (mValid) begin
        if (lastValidCycle >= 0 && cycle - lastValidCycle - 1 > maxGap)
          maxGap = cycle - lastValidCycle - 1;
        lastValidCycle = cycle;
        obsValid++;
      end
      if (rdEn) begin
        obsRdEn++;
        if (sbQ.size() != 0) checkOutput("rdEnLastGroup", weightSelect, 1 << (sbQ[0].groups - 1));
      end
      if (weightSelect != prevWsel && weightSelect != 1)
        checkOutput("wselStep", weightSelect, {prevWsel[MAX_GROUPS-2:0], 1'b0});
      prevWsel = weightSelect;
      if (computeComplete) begin
        obsCc++;
        ccCycle = cycle;
      end
      if (convComplete) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedConv", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("loadCycles",  obsLoadNz, e.loadNz);
          checkOutput("loadMaxAddr", obsMaxAddr, e.loadNz);
          checkOutput("mValidCount", obsValid, e.issues);
          checkOutput("rdEnCount",   obsRdEn, e.rdEn);
          checkOutput("ccCount",     obsCc, 1);
          checkOutput("convLatency", cycle - ccCycle, PIPE_LAT);
          if (e.gapMode == 1) checkOutput("validGap", maxGap, e.gapVal);
          if (e.gapMode == 2) checkOutput("validGapMin", maxGap >= e.gapVal, 1);
        end
        resetMonitor();
      end
    end
  end

  initial begin
    int cnt;
    resetMonitor();
    rst = 1'b1; start = 1'b0; colNum = '0; rowNum = '0; chOut = '0; loadLen = '0;
    fifoReady = 1'b1; mReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy",   busy, 0);
    checkOutput("rstRdEn",   rdEn, 0);
    checkOutput("rstValid",  mValid, 0);
    checkOutput("rstCc",     computeComplete, 0);
    checkOutput("rstConv",   convComplete, 0);
    checkOutput("rstAddr",   weightAddrb, 0);
    checkOutput("rstWsel",   weightSelect, 1);
    @(posedge clk); #1;

    $display("[TB] job A: 4 cols, 2 rows, 32 channels, load 44");
    applyStimulus(4, 2, 32, 44, 0, 0);
    waitJobDone(400);

    $display("[TB] job B: 20 channels -> 3 groups");
    applyStimulus(2, 1, 20, 5, 1, 0);
    waitJobDone(200);

    $display("[TB] job C: m_ready dropped for 3 cycles mid-row");
    applyStimulus(4, 1, 16, 3, 1, 3);
    waitRdEn(100);
    mReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 mReady = 1'b1;
    waitJobDone(200);

    $display("[TB] job D: fifo_ready low for 10 cycles before row 2");
    applyStimulus(2, 2, 8, 2, 2, 10);
    waitRdEn(100);
    waitRdEn(10);
    fifoReady = 1'b0;
    repeat (10) @(posedge clk);
    #1 fifoReady = 1'b1;
    waitJobDone(200);

    $display("[TB] job E: reset during compute");
    applyStimulus(4, 2, 32, 3, 0, 0);
    waitRdEn(100);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortBusy",  busy, 0);
    checkOutput("abortRdEn",  rdEn, 0);
    checkOutput("abortValid", mValid, 0);
    checkOutput("abortAddr",  weightAddrb, 0);
    checkOutput("abortWsel",  weightSelect, 1);
    checkOutput("abortCc",    computeComplete, 0);
    rst = 1'b0;
    sbQ.delete();
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (mValid || convComplete) cnt++;
    end
    checkOutput("postAbortStrobes", cnt, 0);
    @(posedge clk); #1;

    $display("[TB] job F: zero sizes, start pulsed while busy");
    applyStimulus(0, 1, 0, 10, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    colNum = FEAT_W'(3); chOut = 8'd64; loadLen = ADDR_W'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitJobDone(200);
    repeat (5) @(posedge clk);
    #1 checkOutput("idleAfterF", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
